// File: rtl/led_bar_pkg.sv
// -----------------------------------------------------------------------------
// led_bar_pkg
//   Shared definitions for the LED bar decoder: controller state encoding,
//   bar geometry, and the level-to-LED pattern function.
//
//   Build option:
//     LED_BAR_THERMO_EN  defined   -> thermometer bar (all LEDs 0..level lit)
//                        undefined -> one-hot bar (only LED[level] lit)
//   In both modes the highest lit LED index equals the displayed level, so a
//   priority encoder on the bar recovers the level with valid=1.  A blank bar
//   gives valid=0.
// -----------------------------------------------------------------------------
package led_bar_pkg;

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      HOLD  = 2'd1,
      MOVE  = 2'd2
   } bar_state_e;

   localparam logic [3:0] MAX_LEVEL = 4'd9;
   localparam int         NUM_LEDS  = 10;

   // Clamp a requested value into the displayable range 0..MAX_LEVEL.
   function automatic logic [3:0] sat_level(input logic [3:0] v);
      return (v > MAX_LEVEL) ? MAX_LEVEL : v;
   endfunction

   // LED drive for a displayed level (level is always 0..MAX_LEVEL here).
   function automatic logic [NUM_LEDS-1:0] pattern(input logic [3:0] lvl);
      logic [NUM_LEDS-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef LED_BAR_THERMO_EN
         p[i] = (i <= int'(lvl));
`else
         p[i] = (i == int'(lvl));
`endif
      end
      return p;
   endfunction

endpackage

// File: rtl/led_bar_decoder_step_ticker.sv
// -----------------------------------------------------------------------------
// step_ticker
//   Animation prescaler.  While enabled, counts clock cycles and raises tick_o
//   for one cycle every STEP_DIV enabled cycles.  clr_i forces the count back
//   to zero, so the first tick after a clear lands STEP_DIV cycles later.
//
//   Ports:
//     clk     in   system clock, rising edge
//     rst_n   in   asynchronous active-low reset
//     clr_i   in   synchronous clear of the count (dominates en_i)
//     en_i    in   count enable
//     tick_o  out  one-cycle step strobe (combinational from the count)
// -----------------------------------------------------------------------------
module step_ticker #(
   parameter int STEP_DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int               CNT_W = $clog2(STEP_DIV + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The strobe is asserted in the last cycle of each period so that the
   // consumer acts on the edge that closes the period.
   assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_bar_decoder.sv
// -----------------------------------------------------------------------------
// led_bar_decoder
//   Drives a 10-LED bar so that a priority encoder reading the bar recovers the
//   requested value.  New targets are reached by stepping the displayed level
//   one position per animation tick rather than jumping.
//
//   Build option: LED_BAR_THERMO_EN selects the thermometer pattern; without it
//   the bar is one-hot (see led_bar_pkg::pattern).
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     in_val    in   requested value, 0..9 (10..15 saturate to 9)
//     in_valid  in   1 = display in_val, 0 = blank the bar
//     in_load   in   request strobe, taken when in_load & ready at an edge
//     ready     out  high when not animating (registered)
//     busy      out  inverse of ready
//     led       out  LED drive (registered)
//     level     out  displayed position 0..9 (registered)
//     err       out  one-cycle pulse when an accepted load had in_val > 9
// -----------------------------------------------------------------------------
module led_bar_decoder
   import led_bar_pkg::*;
#(
   parameter int STEP_DIV = 5_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          in_val,
   input  logic                in_valid,
   input  logic                in_load,
   output logic                ready,
   output logic                busy,
   output logic [NUM_LEDS-1:0] led,
   output logic [3:0]          level,
   output logic                err
);

   bar_state_e          state_q,  state_d;
   logic [3:0]          level_q,  level_d;
   logic [3:0]          target_q, target_d;
   logic [NUM_LEDS-1:0] led_q,    led_d;
   logic                err_q,    err_d;
   logic                ready_q,  ready_d;

   logic                accept;
   logic                step_tick;
   logic [3:0]          start_lvl;
   logic [3:0]          req_lvl;
   logic [3:0]          step_lvl;

   // The prescaler only runs during an animation; holding it cleared
   // elsewhere means every move starts a fresh STEP_DIV period at acceptance.
   step_ticker #(
      .STEP_DIV (STEP_DIV)
   ) u_ticker (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (state_q != MOVE),
      .en_i   (state_q == MOVE),
      .tick_o (step_tick)
   );

   // Loads arriving mid-animation are dropped outright.
   assign accept    = in_load & ready_q;
   assign req_lvl   = sat_level(in_val);
   // A blank bar animates up from position 0.
   assign start_lvl = (state_q == BLANK) ? 4'd0 : level_q;

   // One position toward the target.  MOVE is only entered when the level
   // differs from the target, so this never runs past it or out of 0..9.
   always_comb begin
      step_lvl = level_q;
      if (level_q < target_q) begin
         step_lvl = level_q + 4'd1;
      end else if (level_q > target_q) begin
         step_lvl = level_q - 4'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      target_d = target_q;
      led_d    = led_q;
      ready_d  = ready_q;
      err_d    = 1'b0;

      if (accept) begin
         if (!in_valid) begin
            state_d  = BLANK;
            level_d  = 4'd0;
            target_d = 4'd0;
            led_d    = '0;
            ready_d  = 1'b1;
         end else begin
            target_d = req_lvl;
            err_d    = (in_val > MAX_LEVEL);
            level_d  = start_lvl;
            led_d    = pattern(start_lvl);
            if (req_lvl == start_lvl) begin
               state_d = HOLD;
               ready_d = 1'b1;
            end else begin
               state_d = MOVE;
               ready_d = 1'b0;
            end
         end
      end else if ((state_q == MOVE) && step_tick) begin
         level_d = step_lvl;
         led_d   = pattern(step_lvl);
         // Arrival and ready rise on the same edge as the final step.
         if (step_lvl == target_q) begin
            state_d = HOLD;
            ready_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BLANK;
         level_q  <= 4'd0;
         target_q <= 4'd0;
         led_q    <= '0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         target_q <= target_d;
         led_q    <= led_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   assign ready = ready_q;
   assign busy  = ~ready_q;
   assign led   = led_q;
   assign level = level_q;
   assign err   = err_q;

endmodule

// File: tb/tb_led_bar_decoder.sv
module tb_led_bar_decoder;

   localparam int STEP = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] in_val;
   logic       in_valid;
   logic       in_load;
   logic       ready;
   logic       busy;
   logic [9:0] led;
   logic [3:0] level;
   logic       err;

   int vectors;
   int miscompares;

   led_bar_decoder #(
      .STEP_DIV (STEP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_val   (in_val),
      .in_valid (in_valid),
      .in_load  (in_load),
      .ready    (ready),
      .busy     (busy),
      .led      (led),
      .level    (level),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference bar pattern, built arithmetically rather than bit by bit.
   function automatic logic [9:0] exp_pat(input int lvl);
      int v;
`ifdef LED_BAR_THERMO_EN
      v = (1 << (lvl + 1)) - 1;
`else
      v = 1 << lvl;
`endif
      return 10'(v);
   endfunction

   // Priority encoder as used on the switch side: highest set bit, -1 if none.
   function automatic int prio_enc(input logic [9:0] b);
      int idx;
      idx = -1;
      for (int i = 0; i < 10; i++) begin
         if (b[i]) idx = i;
      end
      return idx;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance n rising edges, landing 1ns after the last one.
   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a load for exactly one edge (edge N); returns 1ns after edge N.
   task automatic load(input logic [3:0] v, input logic vld);
      in_val   = v;
      in_valid = vld;
      in_load  = 1'b1;
      adv(1);
      in_load  = 1'b0;
   endtask

   initial begin
      int enc;
      int cyc;
      vectors     = 0;
      miscompares = 0;
      rst_n    = 1'b0;
      in_val   = 4'd0;
      in_valid = 1'b0;
      in_load  = 1'b0;

      // Reset state
      adv(2);
      check("rst_led",   32'(led),   32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_ready", 32'(ready), 32'h1);
      check("rst_busy",  32'(busy),  32'h0);
      check("rst_err",   32'(err),   32'h0);
      rst_n = 1'b1;
      adv(2);

      // Up move from BLANK to 3
      load(4'd3, 1'b1);
      check("up_led_N",   32'(led),   32'(exp_pat(0)));
      check("up_ready_N", 32'(ready), 32'h0);
      check("up_busy_N",  32'(busy),  32'h1);
      check("up_err_N",   32'(err),   32'h0);
      for (int c = 1; c <= 12; c++) begin
         adv(1);
         check($sformatf("up_level_%0d", c), 32'(level), 32'(c / 4));
         check($sformatf("up_ready_%0d", c), 32'(ready), (c == 12) ? 32'h1 : 32'h0);
      end
      check("up_led_end", 32'(led), 32'(exp_pat(3)));

      // Down move 3 -> 1 with an ignored load while busy
      load(4'd1, 1'b1);
      check("dn_level_N", 32'(level), 32'd3);
      check("dn_ready_N", 32'(ready), 32'h0);
      adv(1);
      in_val   = 4'd7;
      in_valid = 1'b1;
      in_load  = 1'b1;
      adv(1);
      in_load  = 1'b0;
      check("dn_busy_err",  32'(err),   32'h0);
      check("dn_busy_rdy",  32'(ready), 32'h0);
      adv(2);
      check("dn_level_4",   32'(level), 32'd2);
      adv(4);
      check("dn_level_8",   32'(level), 32'd1);
      check("dn_ready_8",   32'(ready), 32'h1);
      adv(8);
      check("dn_level_hold", 32'(level), 32'd1);
      check("dn_led_hold",   32'(led),   32'(exp_pat(1)));

      // Saturation: blank first, then request 12
      load(4'd0, 1'b0);
      check("sat_pre_level", 32'(level), 32'd0);
      load(4'd12, 1'b1);
      check("sat_err_N",   32'(err),   32'h1);
      check("sat_level_N", 32'(level), 32'd0);
      adv(1);
      check("sat_err_N1",  32'(err),   32'h0);
      adv(34);
      check("sat_level_35", 32'(level), 32'd8);
      check("sat_ready_35", 32'(ready), 32'h0);
      adv(1);
      check("sat_level_36", 32'(level), 32'd9);
      check("sat_ready_36", 32'(ready), 32'h1);
      check("sat_led_36",   32'(led),   32'(exp_pat(9)));
      load(4'd9, 1'b1);
      check("same_ready", 32'(ready), 32'h1);
      check("same_busy",  32'(busy),  32'h0);
      check("same_level", 32'(level), 32'd9);
      check("same_err",   32'(err),   32'h0);
      adv(1);
      check("same_ready2", 32'(ready), 32'h1);

      // Blanking from HOLD at 5
      load(4'd5, 1'b1);
      adv(16);
      check("bl_pre_level", 32'(level), 32'd5);
      check("bl_pre_ready", 32'(ready), 32'h1);
      load(4'd5, 1'b0);
      check("bl_led",   32'(led),   32'h0);
      check("bl_level", 32'(level), 32'd0);
      check("bl_ready", 32'(ready), 32'h1);
      check("bl_enc",   32'(prio_enc(led)), 32'hFFFFFFFF);

      // Asynchronous reset in the middle of a move
      load(4'd7, 1'b1);
      adv(5);
      check("ar_pre_level", 32'(level), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_led",   32'(led),   32'h0);
      check("ar_level", 32'(level), 32'd0);
      check("ar_ready", 32'(ready), 32'h1);
      check("ar_busy",  32'(busy),  32'h0);
      check("ar_err",   32'(err),   32'h0);
      adv(1);
      rst_n = 1'b1;
      adv(10);
      check("ar_post_level", 32'(level), 32'd0);
      check("ar_post_led",   32'(led),   32'h0);

      // Round trip through the priority encoder for every target
      for (int t = 0; t <= 9; t++) begin
         load(4'(t), 1'b1);
         cyc = 0;
         while (ready !== 1'b1 && cyc < 9 * STEP + 4) begin
            adv(1);
            cyc++;
         end
         check($sformatf("rt_settle_%0d", t), 32'(ready), 32'h1);
         enc = prio_enc(led);
         check($sformatf("rt_enc_%0d", t),   32'(enc),   32'(t));
         check($sformatf("rt_level_%0d", t), 32'(level), 32'(t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
